// File: rtl/ls_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ls_mem_responder                                             |
// | Description : Single-ported 16-bit memory shared by a CPU port (A, always   |
// |               wins) and a read-only secondary port (B). Optional MMIO_EN    |
// |               maps the top two addresses to LED / switch registers.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ls_mem_responder #(
  parameter int AW         = 10,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [15:0]   a_wdata,
  output logic [15:0]   a_rdata,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic          b_gnt,
  output logic [15:0]   b_rdata,
  output logic          b_rvalid,
  output logic          b_starved,
  input  logic [9:0]    sw_in,
  output logic [9:0]    led_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam int         c_depth      = 2 ** AW;
  localparam logic [7:0] c_starve_max = 8'(STARVE_MAX);

  logic [15:0]   r_mem [c_depth];
  state_t        r_state;
  state_t        w_next;
  logic          w_gnt;
  logic [7:0]    r_starve_cnt;
  logic [15:0]   r_a_rdata;
  logic          r_a_rvalid;
  logic [15:0]   r_b_rdata;
  logic          r_b_rvalid;
  logic [AW-1:0] w_addr;
  logic [15:0]   w_rd_data;
  logic          w_a_wr;
  logic          w_a_rd;
  logic          w_mem_wr;

  // Port A owns the single access slot whenever it is enabled.
  assign w_addr = a_en ? a_addr : b_addr;
  assign w_a_wr = a_en & a_we;
  assign w_a_rd = a_en & ~a_we;

  always_comb begin
    w_next = r_state;
    w_gnt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (b_req) begin
          if (a_en) begin
            w_next = WAIT;
          end else begin
            w_next = GRANT;
            w_gnt  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!b_req) begin
          w_next = IDLE;
        end else if (!a_en) begin
          w_next = GRANT;
          w_gnt  = 1'b1;
        end
      end
      GRANT:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt) begin
        r_starve_cnt <= '0;
      end else if (w_next == WAIT && r_starve_cnt != 8'hFF) begin
        r_starve_cnt <= r_starve_cnt + 8'd1;
      end
    end
  end

`ifdef MMIO_EN
  localparam logic [AW-1:0] c_led_addr = {AW{1'b1}};
  localparam logic [AW-1:0] c_sw_addr  = {{(AW-1){1'b1}}, 1'b0};

  logic [9:0] r_led;
  logic [9:0] r_sw_meta;
  logic [9:0] r_sw_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
      if (w_a_wr && a_addr == c_led_addr) begin
        r_led <= a_wdata[9:0];
      end
    end
  end

  always_comb begin
    w_rd_data = r_mem[w_addr];
    if (w_addr == c_led_addr) begin
      w_rd_data = {6'b0, r_led};
    end else if (w_addr == c_sw_addr) begin
      w_rd_data = {6'b0, r_sw_sync};
    end
  end

  assign w_mem_wr = w_a_wr && (a_addr != c_led_addr) && (a_addr != c_sw_addr);
  assign led_out  = r_led;
`else
  logic w_sw_unused;
  assign w_sw_unused = ^sw_in;
  assign w_rd_data   = r_mem[w_addr];
  assign w_mem_wr    = w_a_wr;
  assign led_out     = '0;
`endif

  // Storage is never cleared; only a write in a reset cycle is suppressed.
  always_ff @(posedge clk) begin
    if (!reset && w_mem_wr) begin
      r_mem[a_addr] <= a_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_rdata  <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rdata  <= '0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= w_a_rd;
      if (w_a_rd) begin
        r_a_rdata <= w_rd_data;
      end
      r_b_rvalid <= w_gnt;
      if (w_gnt) begin
        r_b_rdata <= w_rd_data;
      end
    end
  end

  assign a_rdata   = r_a_rdata;
  assign a_rvalid  = r_a_rvalid;
  assign b_rdata   = r_b_rdata;
  assign b_rvalid  = r_b_rvalid;
  assign b_gnt     = w_gnt & ~reset;
  assign b_starved = ~reset & ~w_gnt & (r_starve_cnt >= c_starve_max);

endmodule
`default_nettype wire

// File: tb/tb_ls_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ls_mem_responder                                          |
// | Description : Self-checking bench: directed scenarios plus random traffic   |
// |               compared against a cycle-level behavioural model.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ls_mem_responder;

  localparam int AW         = 4;
  localparam int STARVE_MAX = 8;
  localparam int DEPTH      = 1 << AW;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          a_en   = 1'b0;
  logic          a_we   = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [15:0]   a_wdata = '0;
  logic          b_req  = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [9:0]    sw_in  = '0;
  logic [15:0]   a_rdata;
  logic          a_rvalid;
  logic          b_gnt;
  logic [15:0]   b_rdata;
  logic          b_rvalid;
  logic          b_starved;
  logic [9:0]    led_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_a_rdata, m_b_rdata;
  logic        m_a_rvalid, m_b_rvalid;
  logic [9:0]  m_led, m_sw1, m_sw2;
  int          m_cnt;
  logic        m_prev_gnt;

  always #5 clk = ~clk;

  ls_mem_responder #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt),
    .b_rdata(b_rdata), .b_rvalid(b_rvalid), .b_starved(b_starved),
    .sw_in(sw_in), .led_out(led_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [AW-1:0] addr);
`ifdef MMIO_EN
    if (int'(addr) == DEPTH - 1) return {6'b0, m_led};
    if (int'(addr) == DEPTH - 2) return {6'b0, m_sw2};
`endif
    return m_mem[addr];
  endfunction

  task automatic m_write(input logic [AW-1:0] addr, input logic [15:0] data);
`ifdef MMIO_EN
    if (int'(addr) == DEPTH - 1) begin
      m_led = data[9:0];
      return;
    end
    if (int'(addr) == DEPTH - 2) return;
`endif
    m_mem[addr] = data;
  endtask

  // One clock: drive just after negedge, check combinational outputs, advance
  // the model across the posedge, then check registered outputs at the next negedge.
  task automatic cycle(input logic rst, input logic ae, input logic we,
                       input logic [AW-1:0] aa, input logic [15:0] wd,
                       input logic br, input logic [AW-1:0] ba,
                       output logic g, output logic st);
    logic exp_g, exp_st;
    reset = rst; a_en = ae; a_we = we; a_addr = aa; a_wdata = wd;
    b_req = br; b_addr = ba;
    #1;
    // B wins only a cycle A leaves free, and never right after its own grant.
    exp_g  = !rst && br && !ae && !m_prev_gnt;
    exp_st = !rst && !exp_g && (m_cnt >= STARVE_MAX);
    g  = b_gnt;
    st = b_starved;
    check_eq("b_gnt", {31'b0, b_gnt}, {31'b0, exp_g});
    check_eq("b_starved", {31'b0, b_starved}, {31'b0, exp_st});
    if (rst) begin
      m_a_rdata = '0; m_b_rdata = '0; m_a_rvalid = 1'b0; m_b_rvalid = 1'b0;
      m_led = '0; m_sw1 = '0; m_sw2 = '0; m_cnt = 0; m_prev_gnt = 1'b0;
    end else begin
      m_b_rvalid = exp_g;
      if (exp_g) begin
        m_b_rdata = m_read(ba);
        m_cnt = 0;
      end else if (br && ae && !m_prev_gnt && m_cnt < 255) begin
        m_cnt++;
      end
      m_a_rvalid = ae && !we;
      if (ae && !we) m_a_rdata = m_read(aa);
      else if (ae && we) m_write(aa, wd);
      m_prev_gnt = exp_g;
      m_sw2 = m_sw1;
      m_sw1 = sw_in;
    end
    @(negedge clk);
    check_eq("a_rdata", {16'b0, a_rdata}, {16'b0, m_a_rdata});
    check_eq("a_rvalid", {31'b0, a_rvalid}, {31'b0, m_a_rvalid});
    check_eq("b_rdata", {16'b0, b_rdata}, {16'b0, m_b_rdata});
    check_eq("b_rvalid", {31'b0, b_rvalid}, {31'b0, m_b_rvalid});
    check_eq("led_out", {22'b0, led_out}, {22'b0, m_led});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic g, st;
    logic br, ae, we, rs;
    logic [AW-1:0] ba;
    int burst;
    m_cnt = 0; m_prev_gnt = 1'b0;

    @(negedge clk);
    cycle(1, 0, 0, '0, '0, 0, '0, g, st);
    cycle(1, 0, 0, '0, '0, 0, '0, g, st);
    check_eq("rst_a_rvalid", {31'b0, a_rvalid}, 32'd0);
    check_eq("rst_b_rvalid", {31'b0, b_rvalid}, 32'd0);
    check_eq("rst_a_rdata", {16'b0, a_rdata}, 32'd0);

    for (int i = 0; i < DEPTH; i++)
      cycle(0, 1, 1, AW'(i), 16'hA000 ^ 16'(i * 16'h0111), 0, '0, g, st);

    // A write then read-back with one-cycle latency
    cycle(0, 1, 1, AW'(5), 16'h1234, 0, '0, g, st);
    cycle(0, 1, 0, AW'(5), '0, 0, '0, g, st);
    check_eq("t1_rdata", {16'b0, a_rdata}, 32'h1234);
    check_eq("t1_rvalid", {31'b0, a_rvalid}, 32'd1);

    // B waits behind three A cycles
    cycle(0, 1, 1, AW'(7), 16'hBEEF, 0, '0, g, st);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, AW'(k), '0, 1, AW'(7), g, st);
      check_eq("t2_no_grant", {31'b0, g}, 32'd0);
    end
    cycle(0, 0, 0, '0, '0, 1, AW'(7), g, st);
    check_eq("t2_grant", {31'b0, g}, 32'd1);
    check_eq("t2_b_rvalid", {31'b0, b_rvalid}, 32'd1);
    check_eq("t2_b_rdata", {16'b0, b_rdata}, 32'hBEEF);
    cycle(0, 0, 0, '0, '0, 0, '0, g, st);

    // Starvation flag rises on the 8th WAIT cycle, clears on grant
    for (int k = 1; k <= 10; k++) begin
      cycle(0, 1, 0, AW'(2), '0, 1, AW'(4), g, st);
      if (k == 8) check_eq("t3_not_yet", {31'b0, st}, 32'd0);
      if (k == 9) check_eq("t3_starved", {31'b0, st}, 32'd1);
    end
    cycle(0, 0, 0, '0, '0, 1, AW'(4), g, st);
    check_eq("t3_grant", {31'b0, g}, 32'd1);
    check_eq("t3_cleared", {31'b0, st}, 32'd0);
    cycle(0, 0, 0, '0, '0, 0, '0, g, st);

    // Same-cycle A write and B request to one address
    cycle(0, 1, 1, AW'(3), 16'h00AA, 1, AW'(3), g, st);
    cycle(0, 0, 0, '0, '0, 1, AW'(3), g, st);
    check_eq("t4_grant", {31'b0, g}, 32'd1);
    check_eq("t4_b_rdata", {16'b0, b_rdata}, 32'h00AA);
    cycle(0, 0, 0, '0, '0, 0, '0, g, st);

    // Top two addresses: LED register / switches (or plain storage)
    cycle(0, 1, 1, AW'(DEPTH - 1), 16'h02A5, 0, '0, g, st);
    cycle(0, 1, 0, AW'(DEPTH - 1), '0, 0, '0, g, st);
    check_eq("t5_top_rd", {16'b0, a_rdata}, 32'h02A5);
`ifdef MMIO_EN
    check_eq("t5_led", {22'b0, led_out}, 32'h2A5);
`else
    check_eq("t5_led", {22'b0, led_out}, 32'h0);
`endif
    sw_in = 10'h155;
    cycle(0, 1, 1, AW'(DEPTH - 2), 16'h7777, 0, '0, g, st);
    cycle(0, 0, 0, '0, '0, 0, '0, g, st);
    cycle(0, 0, 0, '0, '0, 0, '0, g, st);
    cycle(0, 1, 0, AW'(DEPTH - 2), '0, 0, '0, g, st);
`ifdef MMIO_EN
    check_eq("t5_sw_rd", {16'b0, a_rdata}, 32'h0155);
`else
    check_eq("t5_sw_rd", {16'b0, a_rdata}, 32'h7777);
`endif

    // Reset during an A write with B pending
    cycle(0, 1, 1, AW'(9), 16'h1111, 0, '0, g, st);
    cycle(0, 1, 0, AW'(1), '0, 1, AW'(9), g, st);
    cycle(1, 1, 1, AW'(9), 16'hDEAD, 1, AW'(9), g, st);
    check_eq("t6_rst_gnt", {31'b0, g}, 32'd0);
    check_eq("t6_a_rdata", {16'b0, a_rdata}, 32'd0);
    check_eq("t6_b_rvalid", {31'b0, b_rvalid}, 32'd0);
    check_eq("t6_led", {22'b0, led_out}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      cycle(0, 0, 0, '0, '0, 0, '0, g, st);
      check_eq("t6_no_gnt", {31'b0, g}, 32'd0);
    end
    cycle(0, 1, 0, AW'(9), '0, 0, '0, g, st);
    check_eq("t6_mem9", {16'b0, a_rdata}, 32'h1111);

    // Randomised traffic against the model
    br = 1'b0; ba = '0; burst = 0;
    for (int i = 0; i < 800; i++) begin
      if (!br && $urandom_range(0, 2) == 0) begin
        br = 1'b1;
        ba = AW'($urandom);
      end
      if (burst == 0 && $urandom_range(0, 39) == 0) burst = 12;
      ae = (burst > 0) || ($urandom_range(0, 9) < 6);
      if (burst > 0) burst--;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) sw_in = 10'($urandom);
      rs = ($urandom_range(0, 199) == 0);
      cycle(rs, ae, we, AW'($urandom), 16'($urandom), br, ba, g, st);
      if (g || rs) br = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
